muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the RV32M/RV64M instructions. It sits beside the integer ALU in the execute stage. The execute stage hands over a decoded M-extension operation with both operand values and the destination register. The unit computes the result over multiple cycles and returns it with a one-cycle valid pulse, holding `busy` high so the pipeline can stall the issuing instruction.

---
 rtl/muldiv_unit_if.sv | 34 +++
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module   : muldiv_unit_if
// Purpose  : Request/response bundle between the execute stage and muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            req_v;
   logic            req_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_i;
   logic            flush;
   logic            busy;
   logic            resp_v;
   logic [XLEN-1:0] resp_data;
   logic [4:0]      resp_rd;

   modport master (
      output req_v, funct3, rs1_data, rs2_data, rd_i, flush,
      input  req_ready, busy, resp_v, resp_data, resp_rd
   );

   modport slave (
      input  req_v, funct3, rs1_data, rs2_data, rd_i, flush,
      output req_ready, busy, resp_v, resp_data, resp_rd
   );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M/RV64M multiply/divide unit (shift-add / restoring).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   muldiv_unit_if.slave bus
);

   localparam int              C_CW       = $clog2(XLEN + 1);
   localparam logic [C_CW-1:0] C_K_MUL    = C_CW'(XLEN / MUL_BITS);
   localparam logic [C_CW-1:0] C_K_DIV    = C_CW'(XLEN);
   localparam logic [XLEN-1:0] C_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [C_CW-1:0]   cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic              neg_q, neg_d;
   logic              rneg_q, rneg_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [XLEN-1:0]   resp_data_q, resp_data_d;
   logic [4:0]        resp_rd_q, resp_rd_d;

   logic            w_accept, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
   logic            w_is_div, w_div_zero, w_div_ovf;
   logic [XLEN-1:0] w_a_mag, w_b_mag, w_fast;

   assign w_accept   = bus.req_v && (state_q == IDLE) && !bus.flush;
   assign w_a_sgn    = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                       (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
   assign w_b_sgn    = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) ||
                       (bus.funct3 == 3'd6);
   assign w_a_neg    = w_a_sgn && bus.rs1_data[XLEN-1];
   assign w_b_neg    = w_b_sgn && bus.rs2_data[XLEN-1];
   assign w_a_mag    = w_a_neg ? -bus.rs1_data : bus.rs1_data;
   assign w_b_mag    = w_b_neg ? -bus.rs2_data : bus.rs2_data;
   assign w_is_div   = bus.funct3[2];
   assign w_div_zero = (bus.rs2_data == '0);
   assign w_div_ovf  = !bus.funct3[0] && (bus.rs1_data == C_MOST_NEG) &&
                       (bus.rs2_data == '1);
   // Fast results: divide-by-zero takes precedence over the overflow case.
   assign w_fast     = bus.funct3[1] ? (w_div_zero ? bus.rs1_data : '0)
                                     : (w_div_zero ? '1 : bus.rs1_data);

   // Multiply step: acc holds {partial product high half, remaining multiplier bits}.
   logic [XLEN+MUL_BITS-1:0] w_part, w_sum;
   logic [2*XLEN-1:0]        w_mul_nxt;

   assign w_part    = {{MUL_BITS{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[MUL_BITS-1:0]};
   assign w_sum     = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} + w_part;
   assign w_mul_nxt = {w_sum, acc_q[XLEN-1:MUL_BITS]};

   // Divide step: acc holds {partial remainder, dividend bits shifting into quotient}.
   logic [XLEN:0]     w_rsh;
   logic              w_ge;
   logic [XLEN-1:0]   w_rdif, w_rnew;
   logic [2*XLEN-1:0] w_div_nxt;

   assign w_rsh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign w_ge      = (w_rsh >= {1'b0, opb_q});
   assign w_rdif    = w_rsh[XLEN-1:0] - opb_q;
   assign w_rnew    = w_ge ? w_rdif : w_rsh[XLEN-1:0];
   assign w_div_nxt = {w_rnew, acc_q[XLEN-2:0], w_ge};

   logic [2*XLEN-1:0] w_step, w_prod;
   logic [XLEN-1:0]   w_quo, w_rem, w_result;

   assign w_step = op_q[2] ? w_div_nxt : w_mul_nxt;
   assign w_prod = neg_q ? -w_step : w_step;
   assign w_quo  = neg_q ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
   assign w_rem  = rneg_q ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];

   always_comb begin
      case (op_q)
         3'd0:                w_result = w_prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    w_result = w_prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:          w_result = w_quo;
         default:             w_result = w_rem;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      rd_d        = rd_q;
      neg_d       = neg_q;
      rneg_d      = rneg_q;
      acc_d       = acc_q;
      opb_d       = opb_q;
      resp_data_d = resp_data_q;
      resp_rd_d   = resp_rd_q;
      case (state_q)
         IDLE: begin
            if (w_accept) begin
               op_d   = bus.funct3;
               rd_d   = bus.rd_i;
               neg_d  = w_a_neg ^ w_b_neg;
               rneg_d = w_a_neg;
               if (w_is_div && (w_div_zero || w_div_ovf)) begin
                  state_d     = DONE;
                  resp_data_d = w_fast;
                  resp_rd_d   = bus.rd_i;
               end else begin
                  state_d = RUN;
                  cnt_d   = w_is_div ? C_K_DIV : C_K_MUL;
                  acc_d   = {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                  opb_d   = w_is_div ? w_b_mag : w_a_mag;
               end
            end
         end
         RUN: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else begin
               acc_d = w_step;
               cnt_d = cnt_q - C_CW'(1);
               if (cnt_q == C_CW'(1)) begin
                  state_d     = DONE;
                  resp_data_d = w_result;
                  resp_rd_d   = rd_q;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         rd_q        <= '0;
         neg_q       <= 1'b0;
         rneg_q      <= 1'b0;
         acc_q       <= '0;
         opb_q       <= '0;
         resp_data_q <= '0;
         resp_rd_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         neg_q       <= neg_d;
         rneg_q      <= rneg_d;
         acc_q       <= acc_d;
         opb_q       <= opb_d;
         resp_data_q <= resp_data_d;
         resp_rd_q   <= resp_rd_d;
      end
   end

   // A flush arriving in DONE suppresses the pulse as well.
   assign bus.req_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.resp_v    = (state_q == DONE) && !bus.flush;
   assign bus.resp_data = resp_data_q;
   assign bus.resp_rd   = resp_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit in 32/1, 64/4 and 32/4 builds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

   logic clk;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;

   muldiv_unit_if #(.XLEN(32)) b32 ();
   muldiv_unit_if #(.XLEN(64)) b64 ();
   muldiv_unit_if #(.XLEN(32)) b324 ();

   muldiv_unit #(.XLEN(32), .MUL_BITS(1)) dut32  (.clk(clk), .reset_n(reset_n), .bus(b32.slave));
   muldiv_unit #(.XLEN(64), .MUL_BITS(4)) dut64  (.clk(clk), .reset_n(reset_n), .bus(b64.slave));
   muldiv_unit #(.XLEN(32), .MUL_BITS(4)) dut324 (.clk(clk), .reset_n(reset_n), .bus(b324.slave));

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic        rdy;
      logic        busy;
      logic [4:0]  rd;
      logic [63:0] data;
   } st_t;

   function automatic int xl_of(input int s);
      return (s == 1) ? 64 : 32;
   endfunction

   function automatic int mb_of(input int s);
      return (s == 0) ? 1 : 4;
   endfunction

   function automatic st_t st(input int s);
      st_t o;
      case (s)
         0:       o = {b32.resp_v, b32.req_ready, b32.busy, b32.resp_rd, {32'd0, b32.resp_data}};
         1:       o = {b64.resp_v, b64.req_ready, b64.busy, b64.resp_rd, b64.resp_data};
         default: o = {b324.resp_v, b324.req_ready, b324.busy, b324.resp_rd, {32'd0, b324.resp_data}};
      endcase
      return o;
   endfunction

   task automatic drive_req(input int s, input logic v, input logic [2:0] f,
                            input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
      case (s)
         0: begin
            b32.req_v = v; b32.funct3 = f; b32.rs1_data = a[31:0];
            b32.rs2_data = b[31:0]; b32.rd_i = rd;
         end
         1: begin
            b64.req_v = v; b64.funct3 = f; b64.rs1_data = a;
            b64.rs2_data = b; b64.rd_i = rd;
         end
         default: begin
            b324.req_v = v; b324.funct3 = f; b324.rs1_data = a[31:0];
            b324.rs2_data = b[31:0]; b324.rd_i = rd;
         end
      endcase
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: RISC-V M semantics computed with wide plain arithmetic.
   function automatic logic [63:0] ref_op(input int xl, input logic [2:0] f,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
      logic [63:0]         m, a, b, mn, r;
      logic [127:0]        ua, ub, sa, sb, p;
      logic signed [127:0] q;
      logic                dz, ovf;
      m   = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      a   = a_in & m;
      b   = b_in & m;
      mn  = 64'd1 << (xl - 1);
      ua  = {64'd0, a};
      ub  = {64'd0, b};
      sa  = a[xl-1] ? (ua | ~{64'd0, m}) : ua;
      sb  = b[xl-1] ? (ub | ~{64'd0, m}) : ub;
      dz  = (b == 64'd0);
      ovf = (a == mn) && (b == m);
      r   = 64'd0;
      case (f)
         3'd0: begin p = ua * ub; r = p[63:0]; end
         3'd1: begin p = sa * sb; p = p >> xl; r = p[63:0]; end
         3'd2: begin p = sa * ub; p = p >> xl; r = p[63:0]; end
         3'd3: begin p = ua * ub; p = p >> xl; r = p[63:0]; end
         3'd4: begin
            if (dz) r = m;
            else if (ovf) r = a;
            else begin q = $signed(sa) / $signed(sb); r = q[63:0]; end
         end
         3'd5: begin
            if (dz) r = m;
            else begin p = ua / ub; r = p[63:0]; end
         end
         3'd6: begin
            if (dz) r = a;
            else if (ovf) r = 64'd0;
            else begin q = $signed(sa) % $signed(sb); r = q[63:0]; end
         end
         default: begin
            if (dz) r = a;
            else begin p = ua % ub; r = p[63:0]; end
         end
      endcase
      return r & m;
   endfunction

   function automatic int ref_lat(input int s, input logic [2:0] f,
                                  input logic [63:0] a_in, input logic [63:0] b_in);
      int          xl;
      logic [63:0] m, a, b;
      xl = xl_of(s);
      m  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      a  = a_in & m;
      b  = b_in & m;
      if (f[2]) begin
         if ((b == 64'd0) || (!f[0] && (a == (64'd1 << (xl - 1))) && (b == m))) return 1;
         return xl + 1;
      end
      return xl / mb_of(s) + 1;
   endfunction

   function automatic logic [63:0] pick(input int xl);
      case ($urandom_range(0, 7))
         0:       return 64'd0;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'd1 << (xl - 1);
         3:       return 64'($urandom_range(1, 10));
         4:       return -64'($urandom_range(1, 10));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic run_op(input int s, input string tag, input logic [2:0] f,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         output logic [63:0] got);
      st_t         o;
      int          lat;
      logic [63:0] exp;
      exp = ref_op(xl_of(s), f, a, b);
      drive_req(s, 1'b1, f, a, b, rd);
      @(posedge clk); #1;
      drive_req(s, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
      lat = 1;
      o   = st(s);
      while (!o.v && lat < 300) begin
         @(posedge clk); #1;
         lat++;
         o = st(s);
      end
      got = o.data;
      chk({tag, "_data"}, o.data, exp);
      chk({tag, "_rd"}, 64'(o.rd), 64'(rd));
      chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(s, f, a, b)));
      @(posedge clk); #1;
      o = st(s);
      chk({tag, "_pulse_ready"}, 64'({o.v, o.rdy}), 64'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] got;
      logic [2:0]  f;
      int          nresp;

      clk = 1'b0;
      reset_n = 1'b0;
      for (int s = 0; s < 3; s++) drive_req(s, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
      b32.flush = 1'b0; b64.flush = 1'b0; b324.flush = 1'b0;

      #2;
      chk("rst_ready", 64'(b32.req_ready), 64'd1);
      chk("rst_busy", 64'(b32.busy), 64'd0);
      chk("rst_resp_v", 64'(b32.resp_v), 64'd0);
      chk("rst_resp_data", 64'(b32.resp_data), 64'd0);
      chk("rst_resp_rd", 64'(b32.resp_rd), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_op(0, "mul", 3'd0, 64'd7, 64'hFFFF_FFFD, 5'd17, got);
      chk("mul_lit", got, 64'hFFFF_FFEB);
      run_op(0, "mulh", 3'd1, 64'h8000_0000, 64'h8000_0000, 5'd3, got);
      chk("mulh_lit", got, 64'h4000_0000);
      run_op(0, "mulhu", 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd4, got);
      chk("mulhu_lit", got, 64'hFFFF_FFFE);
      run_op(0, "mulhsu", 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd5, got);
      chk("mulhsu_lit", got, 64'hFFFF_FFFF);
      run_op(0, "div", 3'd4, 64'hFFFF_FFF9, 64'd2, 5'd6, got);
      chk("div_lit", got, 64'hFFFF_FFFD);
      run_op(0, "rem", 3'd6, 64'hFFFF_FFF9, 64'd2, 5'd7, got);
      chk("rem_lit", got, 64'hFFFF_FFFF);
      run_op(0, "divu", 3'd5, 64'd100, 64'd7, 5'd8, got);
      chk("divu_lit", got, 64'd14);
      run_op(0, "remu", 3'd7, 64'd100, 64'd7, 5'd9, got);
      chk("remu_lit", got, 64'd2);

      run_op(0, "div0", 3'd4, 64'd5, 64'd0, 5'd10, got);
      chk("div0_lit", got, 64'hFFFF_FFFF);
      run_op(0, "rem0", 3'd6, 64'd5, 64'd0, 5'd11, got);
      chk("rem0_lit", got, 64'd5);
      run_op(0, "divovf", 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 5'd12, got);
      chk("divovf_lit", got, 64'h8000_0000);
      run_op(0, "removf", 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 5'd13, got);
      chk("removf_lit", got, 64'd0);

      // Flush on the 10th RUN cycle with a stray request pulse while busy.
      drive_req(0, 1'b1, 3'd4, 64'd100, 64'd7, 5'd9);
      @(posedge clk); #1;
      drive_req(0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
      chk("flush_busy", 64'(b32.busy), 64'd1);
      chk("flush_not_ready", 64'(b32.req_ready), 64'd0);
      repeat (2) begin @(posedge clk); #1; end
      drive_req(0, 1'b1, 3'd0, 64'd3, 64'd3, 5'd1);
      @(posedge clk); #1;
      drive_req(0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
      repeat (6) begin @(posedge clk); #1; end
      b32.flush = 1'b1;
      @(posedge clk); #1;
      b32.flush = 1'b0;
      chk("flush_ready", 64'(b32.req_ready), 64'd1);
      chk("flush_idle", 64'({b32.busy, b32.resp_v}), 64'd0);
      nresp = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (b32.resp_v) nresp++;
      end
      chk("flush_no_resp", 64'(nresp), 64'd0);
      run_op(0, "post_flush_mul", 3'd0, 64'd12345, 64'd6789, 5'd21, got);

      // Asynchronous reset mid-multiply.
      drive_req(0, 1'b1, 3'd0, 64'h0001_2345, 64'h0000_6789, 5'd22);
      @(posedge clk); #1;
      drive_req(0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
      repeat (10) begin @(posedge clk); #1; end
      #1;
      reset_n = 1'b0;
      #1;
      chk("areset_busy", 64'(b32.busy), 64'd0);
      chk("areset_resp_v", 64'(b32.resp_v), 64'd0);
      chk("areset_resp_data", 64'(b32.resp_data), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("areset_ready", 64'(b32.req_ready), 64'd1);
      nresp = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (b32.resp_v) nresp++;
      end
      chk("areset_no_resp", 64'(nresp), 64'd0);

      run_op(2, "mb4_mul", 3'd0, 64'h1_2345_6789, 64'h10, 5'd2, got);
      chk("mb4_mul_lit", got, 64'h3456_7890);
      run_op(1, "x64_mul", 3'd0, 64'h1_2345_6789, 64'h10, 5'd30, got);
      chk("x64_mul_lit", got, 64'h12_3456_7890);
      run_op(1, "x64_div", 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd31, got);

      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         run_op(0, "rnd32", f, pick(32), pick(32), 5'($urandom_range(0, 31)), got);
      end
      for (int i = 0; i < 20; i++) begin
         f = 3'($urandom_range(0, 7));
         run_op(1, "rnd64", f, pick(64), pick(64), 5'($urandom_range(0, 31)), got);
      end
      for (int i = 0; i < 20; i++) begin
         f = 3'($urandom_range(0, 7));
         run_op(2, "rnd32mb4", f, pick(32), pick(32), 5'($urandom_range(0, 31)), got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
